// File: rtl/cla_wide_add_sched.sv
// cla_wide_add_sched: two-requester multi-word add/subtract scheduler that
// time-shares one 32-bit carry-lookahead adder, one word per cycle, LSW first.

// 32-bit carry-lookahead adder built from 4-bit lookahead groups.
module CLA (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      logic w_cin;
      logic w_c1, w_c2, w_c3, w_cout;
      logic [3:0] g;
      logic [3:0] p;
      assign g = w_g[gi*4 +: 4];
      assign p = w_p[gi*4 +: 4];
      if (gi == 0) begin : g_first
        assign w_cin = i_cin;
      end else begin : g_chain
        assign w_cin = g_grp[gi-1].w_cout;
      end
      assign w_c1   = g[0] | (p[0] & w_cin);
      assign w_c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & w_cin);
      assign w_c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & w_cin);
      assign w_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & w_cin);
      assign o_sum[gi*4 +: 4] = p ^ {w_c3, w_c2, w_c1, w_cin};
    end
  endgenerate

  assign o_cout = g_grp[7].w_cout;
endmodule

module cla_wide_add_sched #(
  parameter int DW = 32,
  parameter int NW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [NW*DW-1:0] i_req0_a,
  input  logic [NW*DW-1:0] i_req0_b,
  input  logic             i_req0_sub,
  input  logic             i_req0_cin,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [NW*DW-1:0] i_req1_a,
  input  logic [NW*DW-1:0] i_req1_b,
  input  logic             i_req1_sub,
  input  logic             i_req1_cin,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [NW*DW-1:0] o_rsp_sum,
  output logic             o_rsp_cout,
  output logic             o_busy
);
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_rr;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [NW*DW-1:0] r_a;
  logic [NW*DW-1:0] r_b;
  logic             r_sub;
  logic             r_id;
  logic [DW-1:0]    r_sum_w [NW];

  logic             w_idle;
  logic             w_g;
  logic             w_hs;
  logic [DW-1:0]    w_a_w [NW];
  logic [DW-1:0]    w_b_w [NW];
  logic [DW-1:0]    w_add_a;
  logic [DW-1:0]    w_add_b;
  logic [DW-1:0]    w_add_sum;
  logic             w_add_cout;
  logic             w_last;

  // Grant: a lone valid requester wins; on contention the round-robin pointer decides.
  assign w_idle = (r_state == S_IDLE);
  assign w_g    = (i_req0_valid & i_req1_valid) ? r_rr : i_req1_valid;
  assign w_hs   = w_idle & (i_req0_valid | i_req1_valid);

  assign o_req0_ready = w_idle & ~i_rst & i_req0_valid & ~w_g;
  assign o_req1_ready = w_idle & ~i_rst & i_req1_valid &  w_g;

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_word
      assign w_a_w[gi] = r_a[gi*DW +: DW];
      assign w_b_w[gi] = r_b[gi*DW +: DW];
      assign o_rsp_sum[gi*DW +: DW] = r_sum_w[gi];

      // Result word gi is written in the RUN cycle that processes it.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_sum_w[gi] <= '0;
        end else if (r_state == S_RUN && r_k == KW'(gi)) begin
          r_sum_w[gi] <= w_add_sum;
        end
      end
    end
  endgenerate

  // Adder only ever sees registered operands; subtraction is a + ~b + 1.
  assign w_add_a = w_a_w[r_k];
  assign w_add_b = r_sub ? ~w_b_w[r_k] : w_b_w[r_k];
  assign w_last  = (r_k == KW'(NW - 1));

  CLA u_cla (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Control FSM: capture on grant, chain carry word by word, hold result until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_a     <= w_g ? i_req1_a : i_req0_a;
            r_b     <= w_g ? i_req1_b : i_req0_b;
            r_sub   <= w_g ? i_req1_sub : i_req0_sub;
            r_carry <= w_g ? (i_req1_sub | i_req1_cin) : (i_req0_sub | i_req0_cin);
            r_id    <= w_g;
            r_rr    <= ~w_g;
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= w_add_cout;
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == S_DONE);
  assign o_rsp_id    = r_id;
  assign o_rsp_cout  = r_carry;
  assign o_busy      = ~w_idle;
endmodule

// File: tb/tb_cla_wide_add_sched.sv
// Self-checking bench for cla_wide_add_sched with a result scoreboard.
module tb_cla_wide_add_sched;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int W  = NW * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 0, req0_cin = 0, req1_sub = 0, req1_cin = 0;
  logic         rsp_valid, rsp_ready = 0, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    int           hs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_hs = 0;

  cla_wide_add_sched #(.NW(NW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sub(req0_sub), .i_req0_cin(req0_cin),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sub(req1_sub), .i_req1_cin(req1_cin),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin, input int hs);
    exp_t e;
    logic [W:0] t;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    e.id = id; e.sum = t[W-1:0]; e.cout = t[W]; e.hs = hs;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    if (idx) begin req1_a = a; req1_b = b; req1_sub = sub; req1_cin = cin; req1_valid = 1; end
    else     begin req0_a = a; req0_b = b; req0_sub = sub; req0_cin = cin; req0_valid = 1; end
  endtask

  task automatic do_req(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
    bit ok = 0;
    drive(idx, a, b, sub, cin);
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((idx ? req1_ready : req0_ready) === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL req_handshake idx=%0d ready got 0 required 1 within 40 cycles", idx);
      if (idx) req1_valid = 0; else req0_valid = 0;
      return;
    end
    sb.push_back(model(idx, a, b, sub, cin, cyc));
    last_hs = cyc;
    $display("REQ  id=%0d a=%h b=%h sub=%0d cin=%0d cycle=%0d", idx, a, b, sub, cin, cyc);
    @(posedge clk);
    #1;
    if (idx) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_rsp(input string name, input int stall);
    bit   ok = 0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s rsp_valid got 0 required 1 within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected response sum=%h", name, rsp_sum);
      rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
      return;
    end
    e = sb.pop_front();
    $display("RSP  %s id=%0d sum=%h cout=%0d cycle=%0d", name, rsp_id, rsp_sum, rsp_cout, cyc);
    checks++;
    if (cyc !== e.hs + NW + 1) begin
      failures++;
      $display("FAIL %s latency got %0d required %0d", name, cyc - e.hs, NW + 1);
    end
    checks++;
    if (rsp_sum !== e.sum) begin
      failures++;
      $display("FAIL %s sum got %h required %h", name, rsp_sum, e.sum);
    end
    checks++;
    if (rsp_id !== e.id) begin
      failures++;
      $display("FAIL %s id got %0d required %0d", name, rsp_id, e.id);
    end
    checks++;
    if (rsp_cout !== e.cout) begin
      failures++;
      $display("FAIL %s cout got %0d required %0d", name, rsp_cout, e.cout);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== e.sum || rsp_id !== e.id || rsp_cout !== e.cout ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s stall%0d got v=%0d sum=%h id=%0d cout=%0d rdy=%0d%0d required v=1 sum=%h id=%0d cout=%0d rdy=00",
                 name, s, rsp_valid, rsp_sum, rsp_id, rsp_cout, req0_ready, req1_ready, e.sum, e.id, e.cout);
      end
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s after_ack busy=%0d rsp_valid=%0d required 0 0", name, busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    drive(0, rnd128(), rnd128(), 0, 1);
    drive(1, rnd128(), rnd128(), 1, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0 || rsp_valid !== 0 || rsp_id !== 0 ||
        rsp_sum !== '0 || rsp_cout !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL reset_state got rdy=%0d%0d v=%0d id=%0d sum=%h cout=%0d busy=%0d required all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy);
    end
    rst = 0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy0=%0d rdy1=%0d busy=%0d required 1 0 0",
               req0_ready, req1_ready, busy);
    end
    req0_valid = 0;
    req1_valid = 0;
    $display("TEST reset done");
  endtask

  task automatic test_carry_chain();
    do_req(0, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 0, 0);
    wait_rsp("carry_chain", 0);
    do_req(0, {W{1'b1}}, '0, 0, 1);
    wait_rsp("carry_wrap", 0);
  endtask

  task automatic test_subtract();
    for (int c = 0; c < 2; c++) begin
      do_req(1, 128'd5, 128'd3, 1, c[0]);
      wait_rsp("sub_5_3", 0);
      do_req(1, 128'd0, 128'd1, 1, c[0]);
      wait_rsp("sub_0_1", 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_req(i[0], rnd128(), rnd128(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      wait_rsp("random", 0);
    end
  endtask

  task automatic test_arbitration();
    logic         exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] a0, b0, a1, b1;
    bit           ok;
    logic         g;
    a0 = rnd128(); b0 = rnd128(); a1 = rnd128(); b1 = rnd128();
    drive(0, a0, b0, 0, 1);
    drive(1, a1, b1, 1, 0);
    #1;
    for (int n = 0; n < 4; n++) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin ok = 1; break; end
        @(negedge clk);
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL arb_grant%0d no ready within 40 cycles", n);
        break;
      end
      g = req1_ready;
      checks++;
      if (g !== exp_g[n]) begin
        failures++;
        $display("FAIL arb_order%0d granted %0d required %0d", n, g, exp_g[n]);
      end
      sb.push_back(g ? model(1'b1, a1, b1, 1'b1, 1'b0, cyc) : model(1'b0, a0, b0, 1'b0, 1'b1, cyc));
      $display("REQ  arbitration grant=%0d cycle=%0d", g, cyc);
      @(posedge clk);
      #1;
      if (n == 3) begin req0_valid = 0; req1_valid = 0; end
      wait_rsp("arbitration", 0);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    do_req(1, rnd128(), rnd128(), 0, 0);
    prev = last_hs;
    for (int n = 0; n < 2; n++) begin
      wait_rsp("b2b", 0);
      do_req(1, rnd128(), rnd128(), 1, 0);
      checks++;
      if (last_hs - prev !== NW + 2) begin
        failures++;
        $display("FAIL b2b_period got %0d required %0d", last_hs - prev, NW + 2);
      end
      prev = last_hs;
    end
    wait_rsp("b2b", 0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1;
    a1 = rnd128(); b1 = rnd128();
    do_req(0, rnd128(), rnd128(), 0, 1);
    drive(1, a1, b1, 0, 0);
    wait_rsp("backpressure", 3);
    do_req(1, a1, b1, 0, 0);
    wait_rsp("bp_waiter", 0);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 0;
    do_req(0, rnd128(), rnd128(), 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    checks++;
    if (busy !== 0 || rsp_valid !== 0 || rsp_sum !== '0 || rsp_cout !== 0 || rsp_id !== 0 ||
        req0_ready !== 0 || req1_ready !== 0) begin
      failures++;
      $display("FAIL mid_reset got busy=%0d v=%0d sum=%h cout=%0d id=%0d required all 0",
               busy, rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    sb.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_reset_no_rsp got response required none");
    end
    do_req(0, 128'hFFFFFFFF, 128'h1, 0, 0);
    wait_rsp("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_subtract();
    test_arbitration();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
